// File: rtl/store_drain_unit.sv
// Committed-store drain queue: buffers retired stores in commit order and writes them
// to data memory one at a time, freeing the matching store-buffer entry on each ack.
module store_drain_unit #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid,
    input  logic [31:0] commit_addr,
    input  logic [31:0] commit_data,
    input  logic [2:0]  commit_funct3,
    input  logic [31:0] commit_inst_num,
    output logic        commit_ready,
    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    output logic        release_valid,
    output logic [31:0] release_addr,
    output logic [31:0] release_inst_num,
    output logic        store_err,
    output logic [3:0]  count,
    output logic        empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] addr_mem  [DEPTH];
    logic [31:0] wdata_mem [DEPTH];
    logic [3:0]  be_mem    [DEPTH];
    logic [31:0] inst_mem  [DEPTH];

    logic [31:0] dmem_addr_q, dmem_wdata_q;
    logic [3:0]  dmem_be_q;
    logic        release_valid_q;
    logic [31:0] release_addr_q, release_inst_q;
    logic        store_err_q;

    logic        legal;
    logic        push;
    logic        pop;
    logic        load;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;

    assign commit_ready = (count_q != CW'(DEPTH));

    // Misaligned halfword/word or unknown width is dropped and flagged, never queued.
    always_comb begin
        legal      = 1'b0;
        lane_be    = 4'b0000;
        lane_wdata = 32'h0;
        case (commit_funct3)
            3'b000: begin
                legal      = 1'b1;
                lane_be    = 4'b0001 << commit_addr[1:0];
                lane_wdata = {4{commit_data[7:0]}};
            end
            3'b001: begin
                legal      = ~commit_addr[0];
                lane_be    = commit_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{commit_data[15:0]}};
            end
            3'b010: begin
                legal      = (commit_addr[1:0] == 2'b00);
                lane_be    = 4'b1111;
                lane_wdata = commit_data;
            end
            default: begin
                legal      = 1'b0;
            end
        endcase
    end

    assign push = commit_valid && commit_ready && legal;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_REQ;
                    load    = 1'b1;
                end
            end
            S_REQ: begin
                if (dmem_ack) begin
                    state_d = S_IDLE;
                    pop     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Payload storage carries no reset; occupancy is tracked solely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q]  <= commit_addr;
            wdata_mem[wr_ptr_q] <= lane_wdata;
            be_mem[wr_ptr_q]    <= lane_be;
            inst_mem[wr_ptr_q]  <= commit_inst_num;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            dmem_addr_q     <= '0;
            dmem_wdata_q    <= '0;
            dmem_be_q       <= '0;
            release_valid_q <= 1'b0;
            release_addr_q  <= '0;
            release_inst_q  <= '0;
            store_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            release_valid_q <= pop;
            store_err_q     <= commit_valid && commit_ready && !legal;
            if (load) begin
                dmem_addr_q  <= {addr_mem[rd_ptr_q][31:2], 2'b00};
                dmem_wdata_q <= wdata_mem[rd_ptr_q];
                dmem_be_q    <= be_mem[rd_ptr_q];
            end
            if (pop) begin
                release_addr_q <= addr_mem[rd_ptr_q];
                release_inst_q <= inst_mem[rd_ptr_q];
            end
        end
    end

    assign dmem_req         = (state_q == S_REQ);
    assign dmem_addr        = dmem_addr_q;
    assign dmem_wdata       = dmem_wdata_q;
    assign dmem_be          = dmem_be_q;
    assign release_valid    = release_valid_q;
    assign release_addr     = release_addr_q;
    assign release_inst_num = release_inst_q;
    assign store_err        = store_err_q;
    assign count            = 4'(count_q);
    assign empty            = (count_q == '0);

endmodule
